// File: rtl/seq_mul_256.sv
// seq_mul_256: digit-serial 256x256 unsigned shift-add multiplier with start/done handshake
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    request a multiply, sampled only when idle
//   a, b     256-bit operands, latched on the accepting edge
//   busy     high while a multiply is in progress
//   done     one-cycle pulse when product is valid
//   product  512-bit a*b, held until the next done
// Optional macro SEQ_MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero.
module seq_mul_256 #(
  parameter int DIGIT_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] a,
  input  logic [255:0] b,
  output logic         busy,
  output logic         done,
  output logic [511:0] product
);
  localparam int N_DIG = 256 / DIGIT_W;
  localparam int AW = 512 + DIGIT_W;
  localparam int PW = 256 + DIGIT_W;
  localparam int CW = $clog2(N_DIG + 1);
  typedef enum logic {IDLE, MUL} state_t;
  state_t r_state;
  logic [255:0] r_a, r_b;
  logic [AW-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] w_pp;
  logic [AW-1:0] w_acc_nxt;
  logic [511:0] w_prod;
  logic w_last;
  assign w_pp = PW'(r_a) * PW'(r_b[DIGIT_W-1:0]);
  // partial product enters at bit 256 and the whole accumulator slides down one digit
  assign w_acc_nxt = (r_acc + {w_pp, 256'b0}) >> DIGIT_W;
`ifdef SEQ_MUL_EARLY_TERM_EN
  logic [AW-1:0] w_acc_sh;
  assign w_last = (r_cnt == CW'(1)) || ((r_b >> DIGIT_W) == '0);
  // skipped digits would only have shifted zeros in, so realign by the digits left
  assign w_acc_sh = w_acc_nxt >> ((r_cnt - CW'(1)) * DIGIT_W);
  assign w_prod = w_acc_sh[511:0];
`else
  assign w_last = r_cnt == CW'(1);
  assign w_prod = w_acc_nxt[511:0];
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a <= '0;
      r_b <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      product <= '0;
    end else if (r_state == IDLE) begin
      done <= 1'b0;
      if (start) begin
        r_a <= a;
        r_b <= b;
        r_acc <= '0;
        r_cnt <= CW'(N_DIG);
        busy <= 1'b1;
        r_state <= MUL;
      end
    end else begin
      r_acc <= w_acc_nxt;
      r_b <= r_b >> DIGIT_W;
      r_cnt <= r_cnt - CW'(1);
      if (w_last) begin
        product <= w_prod;
        done <= 1'b1;
        busy <= 1'b0;
        r_state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_seq_mul_256.sv
// tb_seq_mul_256: directed and random checks of seq_mul_256 against a plain a*b reference
module tb_seq_mul_256;
  localparam int D = 4;
  localparam int N_DIG = 256 / D;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [255:0] a = '0, b = '0;
  logic busy, done;
  logic [511:0] product;
  int vectors = 0;
  int miscompares = 0;
  int n;
  int busy_bad;
  int dones;
  logic [255:0] hi;
  logic [255:0] ones;
  logic [255:0] ta, tb;
  logic [511:0] held;

  seq_mul_256 #(.DIGIT_W(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] ref_mul(logic [255:0] x, logic [255:0] y);
    logic [511:0] xx, yy;
    xx = {256'b0, x};
    yy = {256'b0, y};
    return xx * yy;
  endfunction

  function automatic int exp_lat(logic [255:0] y);
    int m = -1;
    for (int i = 0; i < 256; i++) if (y[i]) m = i;
`ifdef SEQ_MUL_EARLY_TERM_EN
    return (m < 0) ? 1 : (m + D) / D;
`else
    return (m >= -1) ? N_DIG : 0;
`endif
  endfunction

  function automatic logic [255:0] rnd();
    logic [255:0] r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
    return r;
  endfunction

  task automatic chk(string tag, logic [511:0] obs, logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(logic [255:0] x, logic [255:0] y);
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = rnd();
    b = rnd();
    n = 0;
    busy_bad = 0;
  endtask

  task automatic wait_done();
    while (done !== 1'b1 && n < 400) begin
      if (busy !== 1'b1) busy_bad++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run(string tag, logic [255:0] x, logic [255:0] y);
    launch(x, y);
    wait_done();
    chk({tag, "_lat"}, 512'(n), 512'(exp_lat(y)));
    chk({tag, "_prod"}, product, ref_mul(x, y));
    chk({tag, "_busy_during"}, 512'(busy_bad), 512'(0));
    chk({tag, "_busy_at_done"}, 512'(busy), 512'(0));
    @(negedge clk);
    chk({tag, "_done_1cyc"}, 512'(done), 512'(0));
    chk({tag, "_prod_held"}, product, ref_mul(x, y));
  endtask

  initial begin
    ones = '1;
`ifdef SEQ_MUL_EARLY_TERM_EN
    hi = 256'b1 << 255;
`else
    hi = '0;
`endif
    #12;
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_done", 512'(done), 512'(0));
    chk("rst_prod", product, 512'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run("a3b5", 256'd3, 256'd5);
    run("max", ones, ones);
    chk("max_formula", product, (512'b0 - (512'b1 << 257)) + 512'd1);
    run("a0bmax", '0, ones);
    run("b0", rnd(), '0);
    run("b1", 256'hABC, 256'd1);
    run("b2p255", ones, 256'b1 << 255);
    for (int i = 0; i < 6; i++) begin
      ta = rnd();
      tb = rnd() >> $urandom_range(255, 0);
      run($sformatf("rnd%0d", i), ta, tb);
    end
    launch(256'd7, 256'd9 | hi);
    repeat (10) @(negedge clk);
    n += 10;
    a = 256'd2;
    b = 256'd2;
    start = 1'b1;
    @(negedge clk);
    n++;
    start = 1'b0;
    wait_done();
    chk("ign_lat", 512'(n), 512'(exp_lat(256'd9 | hi)));
    chk("ign_prod", product, ref_mul(256'd7, 256'd9 | hi));
    dones = 0;
    repeat (80) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    chk("ign_no_second_done", 512'(dones), 512'(0));
    held = product;
    launch(rnd(), 256'd5 | hi);
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 512'(busy), 512'(0));
    chk("abort_done", 512'(done), 512'(0));
    chk("abort_prod", product, 512'(0));
    chk("abort_prev_nonzero", 512'(held != '0), 512'(1));
    @(negedge clk);
    rst_n = 1'b1;
    run("after_rst", 256'd11, 256'd13);
    launch(256'd2, 256'd3 | hi);
    wait_done();
    chk("b2b1_lat", 512'(n), 512'(exp_lat(256'd3 | hi)));
    chk("b2b1_prod", product, ref_mul(256'd2, 256'd3 | hi));
    a = 256'd4;
    b = 256'd5 | hi;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    busy_bad = 0;
    chk("b2b_done_fell", 512'(done), 512'(0));
    chk("b2b_busy", 512'(busy), 512'(1));
    chk("b2b_prod_old", product, ref_mul(256'd2, 256'd3 | hi));
    wait_done();
    chk("b2b2_lat", 512'(n), 512'(exp_lat(256'd5 | hi)));
    chk("b2b2_prod", product, ref_mul(256'd4, 256'd5 | hi));
    chk("b2b2_busy_during", 512'(busy_bad), 512'(0));
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
